ram_responder: RTL

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/cpu_bus_pkg.sv | 20 ++
 rtl/ram_array.sv | 31 +++
 rtl/ram_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU bus widths, responder state enum and parity helper
package cpu_bus_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;
    localparam int RAM_AW = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        RD_DRIVE = 2'd2,
        WR_DONE  = 2'd3
    } resp_state_t;

    // Even-parity bit: makes the total count of ones in {bit, word} even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - word storage with synchronous write and asynchronous read
module ram_array
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = DATA_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [RAM_AW-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] w_idx;

    // Addresses wrap modulo DEPTH so smaller arrays still alias cleanly.
    assign w_idx   = IDX_W'(32'(i_addr) % DEPTH);
    assign o_rdata = r_mem[w_idx];

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - CPU bus RAM responder with wait states; RAM_PARITY_EN adds per-word parity
module ram_responder
    import cpu_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH       = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ena,
    input  logic              rd,
    input  logic              wr,
    inout  wire  [DATA_W-1:0] data,
    output logic              ready,
    output logic              err
);

`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [2:0] LAST_CNT = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    resp_state_t       r_state;
    resp_state_t       w_next;
    logic [2:0]        r_cnt;
    logic [RAM_AW-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr;
    logic              r_wr_first;
    logic              r_err;
    logic              w_abort;
    logic              w_ready;
    logic              w_oe;
    logic              w_we;
    logic              w_par_err;
    logic [MEM_W-1:0]  w_mem_wdata;
    logic [MEM_W-1:0]  w_mem_rdata;
    logic [DATA_W-1:0] w_rd_byte;
    logic [2:0]        w_unused_addr_hi;

    assign w_unused_addr_hi = addr[ADDR_W-1:RAM_AW];

    // The strobe that started the access must stay up, with ena, through WAIT.
    assign w_abort = r_is_wr ? !(wr && ena) : !(rd && ena);

    assign w_rd_byte = w_mem_rdata[DATA_W-1:0];

`ifdef RAM_PARITY_EN
    assign w_mem_wdata = {even_parity(r_wdata), r_wdata};
    assign w_par_err   = w_mem_rdata[DATA_W] != even_parity(w_rd_byte);
`else
    assign w_mem_wdata = r_wdata;
    assign w_par_err   = 1'b0;
`endif

    ram_array #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; new accesses are only accepted from IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (ena && rd && !wr) begin
                    w_next = (WAIT_CYCLES == 0) ? RD_DRIVE : WAIT;
                end else if (ena && wr && !rd) begin
                    w_next = (WAIT_CYCLES == 0) ? WR_DONE : WAIT;
                end
            end
            WAIT: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_next = r_is_wr ? WR_DONE : RD_DRIVE;
                end
            end
            RD_DRIVE: begin
                if (!(rd && ena)) begin
                    w_next = IDLE;
                end
            end
            WR_DONE: begin
                if (!wr) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs; read data is released combinationally as soon as rd or ena drops.
    always_comb begin
        w_ready = 1'b0;
        w_oe    = 1'b0;
        w_we    = 1'b0;
        case (r_state)
            RD_DRIVE: begin
                w_ready = rd && ena;
                w_oe    = rd && ena;
            end
            WR_DONE: begin
                w_ready = r_wr_first;
                w_we    = r_wr_first;
            end
            default: ;
        endcase
    end

    // Access latches, wait counter, first-cycle-of-write marker and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
            r_wr_first <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cnt      <= (r_state == WAIT && w_next == WAIT) ? r_cnt + 3'd1 : 3'd0;
            r_wr_first <= (w_next == WR_DONE) && (r_state != WR_DONE);
            case (r_state)
                IDLE: begin
                    if (ena && rd && wr) begin
                        r_err <= 1'b1;
                    end else if (ena && (rd ^ wr)) begin
                        r_addr  <= addr[RAM_AW-1:0];
                        r_is_wr <= wr;
                        if (wr) begin
                            r_wdata <= data;
                        end
                    end
                end
                WAIT: begin
                    if (w_abort) begin
                        r_err <= 1'b1;
                    end
                end
                RD_DRIVE: begin
                    if (w_par_err) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = w_ready;
    assign err   = r_err;
    assign data  = w_oe ? w_rd_byte : {DATA_W{1'bz}};

endmodule
